// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_pkg
//  Purpose  : Shared constants and FSM state type for the floating-point
//             multiplier exponent path.
//  Contents : EXP_W  - default exponent width (binary32)
//             BIAS   - default exponent bias (binary32)
//             state_t- sequencer state encoding
//  Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int BIAS  = 127;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_BIAS = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/addsub_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_nbit
//  Purpose  : Plain W-bit two's-complement adder/subtractor. Shared by the
//             exponent sequencer for both the exponent add and the bias
//             subtract.
//  Ports    : a_i   [W-1:0]  first operand
//             b_i   [W-1:0]  second operand
//             sub_i          0 = a + b, 1 = a - b
//             y_o   [W-1:0]  result (wraps modulo 2^W)
//  Revision : 1.0 - initial release
// ============================================================================
module addsub_nbit #(
  parameter int W = 10
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    if (sub_i) y_o = a_i - b_i;
    else       y_o = a_i + b_i;
  end

endmodule : addsub_nbit
`default_nettype wire

// File: rtl/fp_mul_exp_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_exp_seq
//  Purpose  : Sequential product-exponent unit for an FP multiplier.
//             Computes exp_a + exp_b - BIAS over two cycles on one shared
//             N+2-bit add/sub, then saturates to the biased range and
//             raises overflow / underflow / zero-operand flags.
//  Ports    : clk, rst          clock, async active-high reset
//             in_valid/in_ready operand handshake (ready only when idle)
//             exp_a, exp_b [N]  biased operand exponents
//             out_valid/out_ready result handshake
//             exp_out [N]       saturated biased product exponent
//             ovf, unf, zero    result classification (mutually exclusive)
//  Revision : 1.0 - initial release
// ============================================================================
module fp_mul_exp_seq #(
  parameter int N    = fp_pkg::EXP_W,
  parameter int BIAS = fp_pkg::BIAS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] exp_a,
  input  logic [N-1:0] exp_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] exp_out,
  output logic         ovf,
  output logic         unf,
  output logic         zero
);

  import fp_pkg::*;

  // Two guard bits: one for the carry of a+b, one for the sign after the
  // bias subtract.
  localparam int W = N + 2;
  localparam logic signed [W-1:0] C_MAX_EXP = W'((1 << N) - 2);
  localparam logic signed [W-1:0] C_MIN_EXP = W'(1);
  localparam logic        [W-1:0] C_BIAS    = W'(BIAS);

  state_t         state_q, state_d;
  logic [N-1:0]   opa_q, opa_d;
  logic [N-1:0]   opb_q, opb_d;
  logic [W-1:0]   acc_q, acc_d;
  logic           zero_q, zero_d;

  logic [W-1:0]   w_dp_a, w_dp_b, w_dp_y;
  logic           w_dp_sub;
  logic           w_done, w_ovf, w_unf;

  // --------------------------------------------------------------------------
  // Shared datapath: ADD uses the zero-extended operands, every other state
  // presents acc - BIAS (only consumed in BIAS).
  // --------------------------------------------------------------------------
  always_comb begin
    w_dp_a   = acc_q;
    w_dp_b   = C_BIAS;
    w_dp_sub = 1'b1;
    if (state_q == S_ADD) begin
      w_dp_a   = {2'b00, opa_q};
      w_dp_b   = {2'b00, opb_q};
      w_dp_sub = 1'b0;
    end
  end

  addsub_nbit #(
    .W (W)
  ) u_addsub (
    .a_i   (w_dp_a),
    .b_i   (w_dp_b),
    .sub_i (w_dp_sub),
    .y_o   (w_dp_y)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opa_d = exp_a;
          opb_d = exp_b;
          // A zero exponent means a zero operand: skip the arithmetic.
          if ((exp_a == '0) || (exp_b == '0)) begin
            acc_d   = '0;
            zero_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            zero_d  = 1'b0;
            state_d = S_ADD;
          end
        end
      end
      S_ADD: begin
        acc_d   = w_dp_y;
        state_d = S_BIAS;
      end
      S_BIAS: begin
        acc_d   = w_dp_y;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: saturation and flags derive from the held accumulator, so they
  // stay stable for as long as the consumer stalls.
  // --------------------------------------------------------------------------
  assign w_done = (state_q == S_DONE);
  assign w_ovf  = w_done && !zero_q && ($signed(acc_q) > C_MAX_EXP);
  assign w_unf  = w_done && !zero_q && ($signed(acc_q) < C_MIN_EXP);

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = w_done;
  assign ovf       = w_ovf;
  assign unf       = w_unf;
  assign zero      = w_done && zero_q;

  always_comb begin
    exp_out = '0;
    if (w_ovf)                          exp_out = '1;
    else if (w_done && !w_unf && !zero_q) exp_out = acc_q[N-1:0];
  end

endmodule : fp_mul_exp_seq
`default_nettype wire

// File: tb/tb_fp_mul_exp_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_mul_exp_seq
//  Purpose  : Self-checking bench for fp_mul_exp_seq: directed corner pairs,
//             stall/hold, mid-operation reset and random pairs against an
//             arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_exp_seq;

  localparam int N    = 8;
  localparam int BIAS = 127;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] exp_a, exp_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] exp_out;
  logic         ovf, unf, zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp_mul_exp_seq #(.N(N), .BIAS(BIAS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_out   (exp_out),
    .ovf       (ovf),
    .unf       (unf),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: {zero, ovf, unf, exp_out} from the arithmetic definition.
  function automatic logic [10:0] model(input int a, input int b);
    int s;
    s = a + b - BIAS;
    if (a == 0 || b == 0)       return {3'b100, 8'd0};
    else if (s > (1 << N) - 2)  return {3'b010, 8'hFF};
    else if (s < 1)             return {3'b001, 8'd0};
    else                        return {3'b000, 8'(s)};
  endfunction

  // Called at posedge+1. Runs one full transaction with `stall` cycles of
  // out_ready=0 once the result appears.
  task automatic run_txn(input int a, input int b, input int stall);
    logic [10:0] m;
    int          edges;
    int          guard;
    m = model(a, b);
    guard = 0;
    while (!in_ready && guard < 10) begin
      @(posedge clk); #1; guard++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    exp_a     = 8'(a);
    exp_b     = 8'(b);
    out_ready = (stall == 0);
    @(posedge clk); #1;
    edges = 1;
    // Busy-state traffic on in_valid must be ignored.
    exp_a = 8'($urandom_range(0, 255));
    exp_b = 8'($urandom_range(0, 255));
    if (!m[10]) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      check("idle_exp_out_zero", 32'(exp_out), 32'd0);
    end
    while (!out_valid && edges < 8) begin
      @(posedge clk); #1; edges++;
    end
    in_valid = 1'b0;
    check("latency", 32'(edges), m[10] ? 32'd1 : 32'd3);
    check("exp_out", 32'(exp_out), 32'(m[7:0]));
    check("flags", {29'd0, zero, ovf, unf}, {29'd0, m[10:8]});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_exp_out", 32'(exp_out), 32'(m[7:0]));
      check("hold_flags", {29'd0, zero, ovf, unf}, {29'd0, m[10:8]});
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_xfer_valid", 32'(out_valid), 32'd0);
    check("post_xfer_ready", 32'(in_ready), 32'd1);
    check("post_xfer_flags", {28'd0, exp_out == 8'd0, zero, ovf, unf}, 32'd8);
  endtask

  initial begin
    int a_tab[12] = '{130, 200, 10,  0, 254, 255, 1,   1, 255, 128, 1, 127};
    int b_tab[12] = '{127, 200, 10, 100, 127, 127, 127, 126, 255, 128, 1, 0};

    rst = 1'b1; in_valid = 1'b0; exp_a = '0; exp_b = '0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", {21'd0, exp_out, zero, ovf, unf}, 32'd0);
    // Accept must not happen while reset is held.
    in_valid = 1'b1; exp_a = 8'd50; exp_b = 8'd90;
    repeat (2) @(posedge clk);
    #1;
    check("rst_no_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_txn(a_tab[i], b_tab[i], 0);
    run_txn(127, 127, 5);

    // Reset while in BIAS: abort with no result.
    in_valid = 1'b1; exp_a = 8'd150; exp_b = 8'd150;
    @(posedge clk); #1;          // accept -> ADD
    in_valid = 1'b0;
    @(posedge clk); #2;          // now in BIAS
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", 32'(out_valid), 32'd0);
    end
    run_txn(128, 128, 0);

    for (int i = 0; i < 40; i++) begin
      int a, b;
      a = (($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255));
      b = $urandom_range(0, 255);
      run_txn(a, b, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fp_mul_exp_seq
`default_nettype wire

// File: doc/fp_mul_exp_seq.md
FP_MUL_EXP_SEQ -- requirements
Module: fp_mul_exp_seq

Interface
REQ-001 SHALL have parameter N, default 8, exponent width in bits.
REQ-002 SHALL have parameter BIAS, default 127, the exponent bias subtracted after the add.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand pair.
REQ-007 SHALL have port exp_a  input  N  biased exponent of operand A.
REQ-008 SHALL have port exp_b  input  N  biased exponent of operand B.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port exp_out  output  N  biased product exponent, saturated.
REQ-012 SHALL have port ovf  output  1  exponent overflow; result is infinity.
REQ-013 SHALL have port unf  output  1  exponent underflow; result flushes to zero.
REQ-014 SHALL have port zero  output  1  an input exponent was 0; result is zero.

Function
REQ-015 SHALL time-share one N+2-bit signed add/sub datapath for the exponent add and the bias subtract.
REQ-016 SHALL implement the FSM states IDLE, ADD, BIAS and DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE.
REQ-018 SHALL latch exp_a and exp_b on an IDLE edge with in_valid=1; the state then goes to ADD.
REQ-019 SHALL, if a latched exponent is 0, go directly to DONE with acc=0, zero=1, ovf=0 and unf=0.
REQ-020 SHALL, in ADD, perform acc <= zero-extended(a) + zero-extended(b) and go to BIAS.
REQ-021 SHALL, in BIAS, perform acc <= acc - BIAS (signed, N+2 bits) and go to DONE.
REQ-022 SHALL assert out_valid = 1 only in DONE.
REQ-023 SHALL give a normal latency of out_valid asserted 3 edges after the accept edge; the zero bypass has 1 edge.
REQ-024 SHALL, in DONE, set ovf when acc > 2^N-2 and set exp_out to all ones.
REQ-025 SHALL, in DONE, set unf when acc < 1 (signed) and set exp_out to 0.
REQ-026 SHALL, in DONE with no flag set, drive exp_out = acc[N-1:0].
REQ-027 SHALL make ovf, unf and zero mutually exclusive.
REQ-028 SHALL hold exp_out and all flags stable while out_valid=1 and out_ready=0.
REQ-029 SHALL return to IDLE on a DONE edge with out_ready=1; the next pair can be accepted no earlier than the following edge.
REQ-030 SHALL ignore in_valid outside IDLE and SHALL NOT change the operand registers outside IDLE.
REQ-031 SHALL drive exp_out and all flags to 0 when out_valid = 0.

Reset
REQ-032 SHALL, on rst=1 and regardless of clk, set state to IDLE.
REQ-033 SHALL, on rst=1 and regardless of clk, clear acc, the operand registers and all flags to 0.
REQ-034 SHALL hold in_ready=1 and out_valid=0 during reset.
REQ-035 SHALL abort any operation in progress when rst asserts mid-operation, with no result emitted.
REQ-036 SHALL make no accept on the edge coinciding with rst=1; normal operation resumes on the first edge after rst deasserts.

Structure
REQ-037 SHALL place the EXP_W=8 and BIAS=127 constants and the state enum type in shared package fp_pkg.
REQ-038 SHALL contain one sub-module, addsub_nbit (N+2 bits, op select: 0=add, 1=sub), the shared datapath driven by the FSM.
REQ-039 SHALL keep the saturation and flag logic in fp_mul_exp_seq and not in addsub_nbit.

Verification
REQ-040 SHALL cover: exp_a=130, exp_b=127 -> exp_out=130, no flags, out_valid 3 edges after accept.
REQ-041 SHALL cover: exp_a=200, exp_b=200 -> acc=273, ovf=1, exp_out=8'hFF.
REQ-042 SHALL cover: exp_a=10, exp_b=10 -> acc=-107, unf=1, exp_out=0.
REQ-043 SHALL cover: exp_a=0, exp_b=100 -> zero=1, exp_out=0, out_valid 1 edge after accept.
REQ-044 SHALL cover: exp_a=127, exp_b=127 with out_ready=0 for 5 cycles -> exp_out=127 held stable, in_ready=0 throughout, then one transfer.
REQ-045 SHALL cover: rst pulsed while in BIAS -> out_valid never asserts, in_ready=1 immediately, then a fresh 128+128 pair -> 129.
